// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave):
// one aligned doubleword per transfer with byte-lane write strobes.
interface load_store_unit_if #(
  parameter int WIDTH = 64
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       wstrb;
  logic [WIDTH-1:0] rdata;
  logic             ready;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one registered load or store per start pulse over a
// valid/ready data-memory bus, with alignment faults, a request timeout and load extraction.
module load_store_unit #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [1:0]       size_i,
  input  logic             sign_ext_i,
  input  logic [WIDTH-1:0] address_i,
  input  logic [WIDTH-1:0] store_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] load_data_o,
  output logic             fault_o,
  output logic             bus_error_o,
  load_store_unit_if.master dmem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             bus_error_q, bus_error_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    logic m;
    case (sz)
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      2'd3:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] strobe(input logic [1:0] sz, input logic [2:0] lane);
    logic [7:0] s;
    case (sz)
      2'd0:    s = 8'h01 << lane;
      2'd1:    s = 8'h03 << lane;
      2'd2:    s = 8'h0F << lane;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Move the addressed lane down to bit 0, then zero- or sign-extend from its top bit.
  function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] rdata,
                                               input logic [2:0] lane,
                                               input logic [1:0] sz,
                                               input logic sx);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    s = rdata >> {lane, 3'b000};
    case (sz)
      2'd0:    r = {{(WIDTH-8){sx & s[7]}}, s[7:0]};
      2'd1:    r = {{(WIDTH-16){sx & s[15]}}, s[15:0]};
      2'd2:    r = {{(WIDTH-32){sx & s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    lane_d      = lane_q;
    size_d      = size_q;
    sext_d      = sext_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    bus_error_d = bus_error_q;
    load_data_d = load_data_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          fault_d     = 1'b0;
          bus_error_d = 1'b0;
          lane_d      = address_i[2:0];
          size_d      = size_i;
          sext_d      = sign_ext_i;
          cnt_d       = '0;
          state_d     = RESP;
          done_d      = 1'b1;
          if (mem_read_i && mem_write_i) begin
            fault_d = 1'b1;
          end else if (mem_read_i || mem_write_i) begin
            if (misaligned(size_i, address_i[2:0])) begin
              fault_d = 1'b1;
            end else begin
              state_d = REQ;
              done_d  = 1'b0;
              busy_d  = 1'b1;
              req_d   = 1'b1;
              we_d    = mem_write_i;
              addr_d  = {address_i[WIDTH-1:3], 3'b000};
              wdata_d = store_data_i << {address_i[2:0], 3'b000};
              wstrb_d = mem_write_i ? strobe(size_i, address_i[2:0]) : 8'h00;
            end
          end
        end
      end
      REQ: begin
        if (dmem.ready) begin
          state_d = RESP;
          busy_d  = 1'b0;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) load_data_d = extract(dmem.rdata, lane_q, size_q, sext_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_d     = RESP;
            busy_d      = 1'b0;
            req_d       = 1'b0;
            done_d      = 1'b1;
            bus_error_d = 1'b1;
            load_data_d = '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears every output register, so dmem.req drops the moment
  // rst_n falls and an in-flight access is abandoned without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_error_q <= 1'b0;
      load_data_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      state_q     <= state_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      bus_error_q <= bus_error_d;
      load_data_q <= load_data_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign load_data_o = load_data_q;
  assign fault_o     = fault_q;
  assign bus_error_o = bus_error_q;
  assign dmem.req    = req_q;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.wdata  = wdata_q;
  assign dmem.wstrb  = wstrb_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access unit. Consumes the Execute stage outputs: ALU result as effective address, second register operand as store data.
- Performs one load or store per request over a valid/ready handshake to data memory.
- Holds the non-pipelined datapath via busy until the access completes, faults, or times out.
- Returns size-extracted, optionally sign-extended load data for writeback.

Parameters:
- WIDTH, 64 (`WORD), datapath/address width; the memory bus is one aligned doubleword, so 8 byte lanes.
- TIMEOUT, 16, maximum cycles REQ waits for dmem_ready; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request pulse from control
- mem_read  in  1  load request
- mem_write  in  1  store request
- size  in  2  0=byte, 1=half, 2=word, 3=doubleword
- sign_ext  in  1  sign-extend load result (LDURSW/LDURSH/LDURSB)
- address  in  WIDTH  effective address (Execute alu_result)
- store_data  in  WIDTH  store operand (read_data2)
- busy  out  1  access in progress; stalls PC/writeback
- done  out  1  one-cycle completion pulse
- load_data  out  WIDTH  load result, valid while done=1 and held after
- fault  out  1  misaligned or illegal request, valid with done
- bus_error  out  1  timeout, valid with done
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1=write
- dmem_addr  out  WIDTH  doubleword-aligned address {address[WIDTH-1:3],3'b000}
- dmem_wdata  out  WIDTH  lane-shifted store data
- dmem_wstrb  out  8  byte-lane write enables
- dmem_rdata  in  WIDTH  read doubleword
- dmem_ready  in  1  memory accept/complete

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output 0, including load_data, dmem_addr, dmem_wdata and dmem_wstrb. Timeout counter is cleared.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - start=1 latches address, store_data, size, sign_ext and op.
  - Outcome depends on the request:
    - Exactly one of mem_read/mem_write set and aligned: go to REQ; busy=1 and dmem_req=1 from the next cycle.
    - Misaligned or both read and write set: no memory transaction; go to RESP with fault=1.
    - Neither read nor write set: go to RESP with no transaction and no flags.
  - Misaligned means size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or size=3 with addr[2:0]!=0.
- REQ:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable until dmem_ready=1 is sampled.
  - On ready: capture dmem_rdata, drop dmem_req the next cycle, go to RESP.
  - The counter increments each REQ cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT without ready: drop req, go to RESP with bus_error=1 and load_data=0.
- RESP: one cycle. done=1, busy=0 on entry; then return to IDLE.
  - Minimum latency, start to done: 3 cycles (start, REQ with immediate ready, RESP).
  - Fault latency: 2 cycles.
- Store lanes, with lane=addr[2:0]:
  - dmem_wdata = store_data << (8*lane).
  - dmem_wstrb = 0x01<<lane (byte), 0x03<<lane (half), 0x0F<<lane (word), 0xFF (doubleword).
  - Loads drive dmem_wstrb=0.
- Load extract: shift dmem_rdata right by 8*lane, keep low 8/16/32/64 bits, then zero-extend or sign-extend from the top kept bit per sign_ext. For size=3, sign_ext has no effect.
- A store leaves load_data unchanged.
- start while busy=1 or in RESP is ignored; no queueing.
- dmem_ready outside REQ is ignored.
- fault and bus_error are cleared at the next accepted start.
- Reset mid-transaction: dmem_req drops immediately and asynchronously; the partial access is abandoned with no done pulse.

Test Plan:
- Aligned doubleword store: address=0x100, store_data=0x1122334455667788, size=3, ready after 2 cycles. Required: dmem_addr=0x100, wstrb=0xFF, wdata unchanged, req held 3 cycles, done 1 cycle after ready.
- Signed byte load: address=0x105, size=0, sign_ext=1, rdata=0x0000_80FF_0000_0000. Required: load_data=0xFFFFFFFFFFFFFF80; same request with sign_ext=0 gives 0x80.
- Word store at upper half: address=0x204, store_data=0xDEADBEEF, size=2. Required: dmem_addr=0x200, wstrb=0xF0, wdata=0xDEADBEEF_00000000.
- Misaligned half load: address=0x301, size=1. Required: dmem_req never asserts; done and fault at cycle 2; a new start clears fault.
- Timeout: load at 0x400 with dmem_ready tied 0, TIMEOUT=16. Required: req high exactly 16 cycles, then done with bus_error=1 and load_data=0; a stray ready afterwards is ignored.
- Reset mid-REQ: drive reset=0 at cycle 2 of a load. Required: dmem_req, busy and every other output go to 0 asynchronously, no done pulse; after release, a new load completes normally.
